// File: rtl/select_switch_ctrl_if.sv
// Purpose: signal bundle between the select/switch controller and its environment.
// Signals:
//   btn_in    raw push-button level (asynchronous, bouncy)
//   sw_req    one-cycle software toggle request
//   auto_en   level enable for periodic auto toggle
//   vsync_in  vertical sync from the timing generator
//   sel       selector control (0 = a_in, 1 = b_in)
//   blank     forces downstream black output while high
//   busy      a switch sequence is in progress
// Modports: master drives the requests/vsync and observes the outputs; slave is the controller.
interface select_switch_ctrl_if;
    logic btn_in;
    logic sw_req;
    logic auto_en;
    logic vsync_in;
    logic sel;
    logic blank;
    logic busy;

    modport master (
        output btn_in, sw_req, auto_en, vsync_in,
        input  sel, blank, busy
    );

    modport slave (
        input  btn_in, sw_req, auto_en, vsync_in,
        output sel, blank, busy
    );
endinterface

// File: rtl/select_switch_ctrl.sv
// Purpose: frame-synchronous controller for the 2:1 HDMI source selector. Toggle requests from a
//   debounced push-button, a software pulse or an auto-cycle frame timer start a sequence that
//   blanks the output on a frame boundary, flips sel one frame later and keeps blanking for
//   BLANK_FRAMES further frames, so the sink never sees a torn frame.
// Ports:
//   clk    pixel clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    select_switch_ctrl_if.slave: btn_in, sw_req, auto_en, vsync_in in; sel, blank, busy out
module select_switch_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1485000,
    parameter int unsigned BLANK_FRAMES    = 2,
    parameter int unsigned AUTO_FRAMES     = 600,
    parameter bit          VS_POL          = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    select_switch_ctrl_if.slave  bus
);

    localparam int unsigned DebW   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned AutoW  = $clog2(AUTO_FRAMES);
    localparam int unsigned BlankW = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;

    localparam logic [DebW-1:0]   DebMax   = DebW'(DEBOUNCE_CYCLES - 1);
    localparam logic [AutoW-1:0]  AutoMax  = AutoW'(AUTO_FRAMES - 1);
    localparam logic [BlankW-1:0] BlankMax = BlankW'(BLANK_FRAMES - 1);

    typedef enum logic [1:0] {StIdle, StArm, StPre, StPost} state_e;

    // Button path: synchronizer, debouncer and press detector
    logic            btn_s1, btn_s2;
    logic [DebW-1:0] deb_cnt;
    logic            deb_lvl, deb_prev;
    logic            btn_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1   <= 1'b0;
            btn_s2   <= 1'b0;
            deb_cnt  <= '0;
            deb_lvl  <= 1'b0;
            deb_prev <= 1'b0;
        end else begin
            btn_s1   <= bus.btn_in;
            btn_s2   <= btn_s1;
            deb_prev <= deb_lvl;
            // Any sample matching the accepted level restarts the stability run.
            if (btn_s2 == deb_lvl) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DebMax) begin
                deb_cnt <= '0;
                deb_lvl <= btn_s2;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    // Only a press (rising debounced level) requests a toggle; release is ignored.
    assign btn_req = deb_lvl & ~deb_prev;

    // Frame boundary: first cycle vsync is seen at its active level
    logic vs_d;
    logic fb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d <= 1'b0;
        end else begin
            vs_d <= bus.vsync_in;
        end
    end

    assign fb = (bus.vsync_in == VS_POL) && (vs_d != VS_POL);

    // Auto-cycle timer: free-running over frame boundaries while enabled
    logic [AutoW-1:0] auto_cnt;
    logic             auto_req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt <= '0;
        end else if (!bus.auto_en) begin
            auto_cnt <= '0;
        end else if (fb) begin
            auto_cnt <= (auto_cnt == AutoMax) ? '0 : auto_cnt + 1'b1;
        end
    end

    assign auto_req = bus.auto_en && fb && (auto_cnt == AutoMax);

    logic req;
    assign req = btn_req | bus.sw_req | auto_req;

    // Switch sequencer; requests outside StIdle are dropped, not queued
    state_e            state;
    logic              sel_q, blank_q, busy_q;
    logic [BlankW-1:0] frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= StIdle;
            sel_q     <= 1'b0;
            blank_q   <= 1'b0;
            busy_q    <= 1'b0;
            frame_cnt <= '0;
        end else begin
            case (state)
                // A boundary coinciding with the request is not consumed here.
                StIdle: begin
                    if (req) begin
                        state  <= StArm;
                        busy_q <= 1'b1;
                    end
                end
                StArm: begin
                    if (fb) begin
                        state   <= StPre;
                        blank_q <= 1'b1;
                    end
                end
                StPre: begin
                    if (fb) begin
                        state     <= StPost;
                        sel_q     <= ~sel_q;
                        frame_cnt <= '0;
                    end
                end
                StPost: begin
                    if (fb) begin
                        if (frame_cnt == BlankMax) begin
                            state   <= StIdle;
                            blank_q <= 1'b0;
                            busy_q  <= 1'b0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign bus.sel   = sel_q;
    assign bus.blank = blank_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_select_switch_ctrl.sv
`timescale 1ns/1ps
module tb_select_switch_ctrl;

    localparam int unsigned DEB   = 50;
    localparam int unsigned BLANK = 2;
    localparam int unsigned AUTO  = 5;
    localparam int          VP    = 40;  // vsync period in clk cycles

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    select_switch_ctrl_if bus ();

    select_switch_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .BLANK_FRAMES    (BLANK),
        .AUTO_FRAMES     (AUTO),
        .VS_POL          (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a sequence is "frames seen since the request was accepted"
    bit m_s1, m_s2, m_deb, m_deb_prev, m_vs_prev, m_busy, m_sel;
    int m_run, m_acnt, m_nfb;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_s1 = 0; m_s2 = 0; m_deb = 0; m_deb_prev = 0; m_vs_prev = 0;
                m_busy = 0; m_sel = 0; m_run = 0; m_acnt = 0; m_nfb = 0;
            end else begin
                bit vs_act, fb, breq, areq, req;
                vs_act = (bus.vsync_in === 1'b1);
                fb     = vs_act && !m_vs_prev;
                breq   = m_deb && !m_deb_prev;
                areq   = (bus.auto_en === 1'b1) && fb && (m_acnt == AUTO - 1);
                req    = breq || (bus.sw_req === 1'b1) || areq;
                if (!m_busy) begin
                    if (req) begin
                        m_busy = 1;
                        m_nfb  = 0;
                    end
                end else if (fb) begin
                    m_nfb++;
                    if (m_nfb == 2) m_sel = !m_sel;
                    if (m_nfb == 2 + BLANK) m_busy = 0;
                end
                m_vs_prev  = vs_act;
                m_deb_prev = m_deb;
                // Debounced level follows after DEB consecutive differing synced samples.
                if (m_s2 != m_deb) begin
                    m_run++;
                    if (m_run == DEB) begin
                        m_deb = m_s2;
                        m_run = 0;
                    end
                end else begin
                    m_run = 0;
                end
                m_s2 = m_s1;
                m_s1 = (bus.btn_in === 1'b1);
                if (bus.auto_en !== 1'b1) m_acnt = 0;
                else if (fb) m_acnt = (m_acnt + 1) % AUTO;
            end
        end
    end

    // Every-cycle comparison against the model
    initial begin
        forever begin
            @(negedge clk);
            check("sel", bus.sel, m_sel);
            check("blank", bus.blank, (m_busy && m_nfb >= 1));
            check("busy", bus.busy, m_busy);
        end
    end

    // vsync generator: 3-cycle active-high pulse every VP cycles
    bit vs_en = 0;
    int vcnt = 0;
    initial begin
        bus.vsync_in = 1'b0;
        forever begin
            @(negedge clk);
            if (vs_en) begin
                vcnt = (vcnt + 1) % VP;
                bus.vsync_in = (vcnt < 3);
            end else begin
                bus.vsync_in = 1'b0;
            end
        end
    end

    int   cyc = 0;
    int   last_vs_cyc = 0;
    logic vs_prev_s = 1'b0;
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        vs_prev_s <= bus.vsync_in;
        if (bus.vsync_in && !vs_prev_s) last_vs_cyc <= cyc;
    end

    int   flips = 0;
    logic sel_prev = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (bus.sel !== sel_prev) flips++;
            sel_prev = bus.sel;
        end
    end

    // which: 0 = sel, 1 = blank, 2 = busy
    task automatic wait_out(input string name, input int which, input logic val, input int bound,
                            output int n);
        logic cur;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            cur = (which == 0) ? bus.sel : (which == 1) ? bus.blank : bus.busy;
            if (cur === val) break;
            if (n >= bound) begin
                checks++;
                errors++;
                $display("FAIL %s timeout: got %b expected %b", name, cur, val);
                break;
            end
        end
    endtask

    task automatic pulse_sw();
        @(negedge clk);
        bus.sw_req = 1'b1;
        @(negedge clk);
        bus.sw_req = 1'b0;
    endtask

    int n, f0, s0;

    initial begin
        bus.btn_in  = 1'b0;
        bus.sw_req  = 1'b0;
        bus.auto_en = 1'b0;
        vs_en       = 1;

        // Reset held with vsync running and requests arriving
        repeat (100) begin
            @(negedge clk);
            bus.sw_req  = 1'($urandom_range(0, 1));
            bus.auto_en = 1'b1;
        end
        check("rst_sel", bus.sel, 0);
        check("rst_blank", bus.blank, 0);
        check("rst_busy", bus.busy, 0);
        @(negedge clk);
        bus.sw_req  = 1'b0;
        bus.auto_en = 1'b0;
        rst_n       = 1'b1;
        repeat (5) @(negedge clk);

        // Software request: full sequence timing
        pulse_sw();
        check("t2_busy_next", bus.busy, 1);
        check("t2_blank_low", bus.blank, 0);
        wait_out("t2_blank_rise", 1, 1'b1, VP + 4, n);
        check("t2_blank_lat", cyc - last_vs_cyc, 1);
        check("t2_sel_before", bus.sel, 0);
        wait_out("t2_sel_flip", 0, 1'b1, VP + 4, n);
        check("t2_sel_delay", n, VP);
        wait_out("t2_busy_fall", 2, 1'b0, 2 * VP + 4, n);
        check("t2_busy_delay", n, 2 * VP);
        check("t2_blank_fall", bus.blank, 0);

        // Bouncy press: one toggle; clean release: none
        repeat (10) @(negedge clk);
        f0 = flips;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            #1 bus.btn_in = ~bus.btn_in;
        end
        @(negedge clk);
        #1 bus.btn_in = 1'b1;
        repeat (DEB + 7 * VP) @(negedge clk);
        check("t3_press_flips", flips - f0, 1);
        check("t3_idle", bus.busy, 0);
        f0 = flips;
        #1 bus.btn_in = 1'b0;
        repeat (3 * DEB + 6 * VP) @(negedge clk);
        check("t3_release_flips", flips - f0, 0);

        // Auto cycle: three toggles within 3*AUTO+6 frames
        f0 = flips;
        bus.auto_en = 1'b1;
        repeat ((3 * AUTO + 6) * VP) @(negedge clk);
        check("t4_auto_flips", flips - f0, 3);
        bus.auto_en = 1'b0;
        wait_out("t4_idle", 2, 1'b0, 6 * VP, n);
        // Disable mid-count, re-enable: count must restart from zero
        bus.auto_en = 1'b1;
        repeat (2 * VP) @(negedge clk);
        bus.auto_en = 1'b0;
        repeat (VP) @(negedge clk);
        bus.auto_en = 1'b1;
        wait_out("t4_restart_busy", 2, 1'b1, 6 * VP, n);
        check("t4_restart_window", (n >= (AUTO - 1) * VP) && (n <= AUTO * VP + 2), 1);
        bus.auto_en = 1'b0;
        wait_out("t4_idle2", 2, 1'b0, 6 * VP, n);

        // Requests during ARM, PRE and POST are dropped
        repeat (5) @(negedge clk);
        f0 = flips;
        s0 = int'(bus.sel);
        pulse_sw();
        pulse_sw();
        wait_out("t5_pre", 1, 1'b1, 2 * VP, n);
        pulse_sw();
        wait_out("t5_post", 0, 1'(~s0), 2 * VP, n);
        pulse_sw();
        wait_out("t5_idle", 2, 1'b0, 3 * VP, n);
        repeat (5) @(negedge clk);
        check("t5_one_toggle", flips - f0, 1);

        // Button press and software pulse in the same cycle
        f0 = flips;
        @(negedge clk);
        #1 bus.btn_in = 1'b1;
        repeat (DEB + 2) @(negedge clk);
        bus.sw_req = 1'b1;
        @(negedge clk);
        bus.sw_req = 1'b0;
        check("t5_same_cycle_busy", bus.busy, 1);
        wait_out("t5_idle2", 2, 1'b0, 6 * VP, n);
        repeat (5) @(negedge clk);
        check("t5_same_cycle_flips", flips - f0, 1);
        #1 bus.btn_in = 1'b0;
        repeat (DEB + 10) @(negedge clk);

        // Asynchronous reset during PRE
        pulse_sw();
        wait_out("t6_pre", 1, 1'b1, 2 * VP, n);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_sel", bus.sel, 0);
        check("t6_blank", bus.blank, 0);
        check("t6_busy", bus.busy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6 * VP) @(negedge clk);
        check("t6_no_resume_sel", bus.sel, 0);
        check("t6_no_resume_busy", bus.busy, 0);

        // Randomised traffic checked cycle by cycle against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            bus.sw_req = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 299) == 0) bus.auto_en = ~bus.auto_en;
            if ($urandom_range(0, 1999) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            #1;
            if ($urandom_range(0, 39) == 0) bus.btn_in = ~bus.btn_in;
        end
        @(negedge clk);
        bus.sw_req = 1'b0;
        rst_n      = 1'b1;
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
